// File: rtl/cdb_arbiter_if.sv
// Requester-to-CDB bundle for the common data bus arbiter.
// The master modport is the arbiter side; slave is the functional-unit / consumer side.
interface cdb_arbiter_if #(
  parameter int unsigned N_CDB  = 4,
  parameter int unsigned NUM_FU = 8,
  parameter int unsigned PRF_W  = 6,
  parameter int unsigned ROB_W  = 5,
  parameter int unsigned XLEN   = 32
);
  logic                      branch_mispredict;
  logic [NUM_FU-1:0]         fu_valid;
  logic [NUM_FU*PRF_W-1:0]   fu_dest_prf;
  logic [NUM_FU*ROB_W-1:0]   fu_rob_idx;
  logic [NUM_FU*XLEN-1:0]    fu_value;
  logic [NUM_FU*XLEN-1:0]    fu_br_addr;
  logic [NUM_FU-1:0]         fu_br_taken;
  logic [NUM_FU-1:0]         fu_ready;
  logic [N_CDB-1:0]          cdb_valid;
  logic [N_CDB*PRF_W-1:0]    cdb_dest_prf;
  logic [N_CDB*ROB_W-1:0]    cdb_rob_idx;
  logic [N_CDB*XLEN-1:0]     cdb_value;
  logic [N_CDB*XLEN-1:0]     cdb_br_addr;
  logic [N_CDB-1:0]          cdb_br_taken;

  modport master (
    input  branch_mispredict, fu_valid, fu_dest_prf, fu_rob_idx, fu_value, fu_br_addr,
           fu_br_taken,
    output fu_ready, cdb_valid, cdb_dest_prf, cdb_rob_idx, cdb_value, cdb_br_addr, cdb_br_taken
  );

  modport slave (
    output branch_mispredict, fu_valid, fu_dest_prf, fu_rob_idx, fu_value, fu_br_addr,
           fu_br_taken,
    input  fu_ready, cdb_valid, cdb_dest_prf, cdb_rob_idx, cdb_value, cdb_br_addr, cdb_br_taken
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to N_CDB completing functional units per cycle onto a
// registered common data bus; flushed by branch mispredict.
module cdb_arbiter #(
  parameter int unsigned N_CDB  = 4,
  parameter int unsigned NUM_FU = 8,
  parameter int unsigned PRF_W  = 6,
  parameter int unsigned ROB_W  = 5,
  parameter int unsigned XLEN   = 32
) (
  input logic         clock,
  input logic         reset,
  cdb_arbiter_if.master bus
);
  localparam int unsigned PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned SLOT_W = (N_CDB > 1) ? $clog2(N_CDB) : 1;
  localparam int unsigned CNT_W  = $clog2(N_CDB + 1);

  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0]       grant;
  logic [N_CDB-1:0]        slot_hit;
  logic [PTR_W-1:0]        slot_src [N_CDB];
  logic [CNT_W-1:0]        cnt;
  logic [PTR_W:0]          sum;
  logic [PTR_W-1:0]        idx;
  logic                    blocked;

  logic [N_CDB-1:0]        valid_q;
  logic [N_CDB*PRF_W-1:0]  dest_q;
  logic [N_CDB*ROB_W-1:0]  rob_q;
  logic [N_CDB*XLEN-1:0]   value_q;
  logic [N_CDB*XLEN-1:0]   addr_q;
  logic [N_CDB-1:0]        taken_q;

  assign blocked = !reset || bus.branch_mispredict;

  // Scan from rr_ptr with wrap; the k-th hit in scan order lands in slot k.
  always_comb begin
    grant    = '0;
    slot_hit = '0;
    for (int unsigned k = 0; k < N_CDB; k++) slot_src[k] = '0;
    cnt      = '0;
    sum      = '0;
    idx      = '0;
    rr_ptr_d = rr_ptr_q;
    if (!blocked) begin
      for (int unsigned off = 0; off < NUM_FU; off++) begin
        sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
        if (sum >= (PTR_W+1)'(NUM_FU)) sum = sum - (PTR_W+1)'(NUM_FU);
        idx = sum[PTR_W-1:0];
        if (bus.fu_valid[idx] && (cnt < CNT_W'(N_CDB))) begin
          grant[idx]                  = 1'b1;
          slot_hit[cnt[SLOT_W-1:0]]   = 1'b1;
          slot_src[cnt[SLOT_W-1:0]]   = idx;
          cnt                         = cnt + CNT_W'(1);
          rr_ptr_d = (idx == PTR_W'(NUM_FU - 1)) ? '0 : idx + PTR_W'(1);
        end
      end
    end
  end

  assign bus.fu_ready = grant;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      valid_q  <= '0;
      dest_q   <= '0;
      rob_q    <= '0;
      value_q  <= '0;
      addr_q   <= '0;
      taken_q  <= '0;
    end else if (bus.branch_mispredict) begin
      rr_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= slot_hit;
      for (int unsigned k = 0; k < N_CDB; k++) begin
        dest_q[k*PRF_W +: PRF_W] <= bus.fu_dest_prf[slot_src[k]*PRF_W +: PRF_W];
        rob_q[k*ROB_W +: ROB_W]  <= bus.fu_rob_idx[slot_src[k]*ROB_W +: ROB_W];
        value_q[k*XLEN +: XLEN]  <= bus.fu_value[slot_src[k]*XLEN +: XLEN];
        addr_q[k*XLEN +: XLEN]   <= bus.fu_br_addr[slot_src[k]*XLEN +: XLEN];
        taken_q[k]               <= bus.fu_br_taken[slot_src[k]];
      end
    end
  end

  assign bus.cdb_valid    = valid_q;
  assign bus.cdb_dest_prf = dest_q;
  assign bus.cdb_rob_idx  = rob_q;
  assign bus.cdb_value    = value_q;
  assign bus.cdb_br_addr  = addr_q;
  assign bus.cdb_br_taken = taken_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios then randomized traffic against a
// queue-based reference of pending requesters and round-robin order.
module tb_cdb_arbiter;
  localparam int N = 4;
  localparam int F = 8;

  typedef struct {
    logic [3:0]       valid;
    logic [3:0][5:0]  prf;
    logic [3:0][4:0]  rob;
    logic [3:0][31:0] val;
    logic [3:0][31:0] addr;
    logic [3:0]       tkn;
  } rec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cdb_arbiter_if bus_if ();
  cdb_arbiter dut (.clock(clock), .reset(reset), .bus(bus_if));

  rec_t        exp_q[$];
  bit          pv[F];
  logic [5:0]  pprf[F];
  logic [4:0]  prob[F];
  logic [31:0] pval[F];
  logic [31:0] paddr[F];
  logic        ptkn[F];
  int          rr_m = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          n_in = 0;
  int          n_out = 0;
  bit          mon_en = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic new_payload(input int i);
    pv[i]    = 1'b1;
    pprf[i]  = 6'($urandom);
    prob[i]  = 5'($urandom);
    pval[i]  = $urandom;
    paddr[i] = $urandom;
    ptkn[i]  = 1'($urandom);
  endtask

  task automatic set_only(input logic [7:0] m);
    for (int i = 0; i < F; i++) begin
      pv[i] = 1'b0;
      if (m[i]) new_payload(i);
    end
  endtask

  task automatic refill();
    for (int i = 0; i < F; i++) if (!pv[i]) new_payload(i);
  endtask

  // One arbitration cycle: drive pending requesters, check grants, record expected CDB.
  task automatic cycle(input bit rn, input bit mis, input bit use_lit, input logic [7:0] lit);
    logic [7:0] exp_r;
    int         order[$];
    rec_t       r;
    @(negedge clock);
    reset = rn;
    bus_if.branch_mispredict = mis;
    for (int i = 0; i < F; i++) begin
      bus_if.fu_valid[i]         = pv[i];
      bus_if.fu_dest_prf[i*6 +: 6]  = pprf[i];
      bus_if.fu_rob_idx[i*5 +: 5]   = prob[i];
      bus_if.fu_value[i*32 +: 32]   = pval[i];
      bus_if.fu_br_addr[i*32 +: 32] = paddr[i];
      bus_if.fu_br_taken[i]         = ptkn[i];
    end
    #1;
    exp_r = '0;
    if (rn && !mis) begin
      for (int off = 0; off < F; off++) begin
        int i;
        i = (rr_m + off) % F;
        if (pv[i] && order.size() < N) begin
          order.push_back(i);
          exp_r[i] = 1'b1;
        end
      end
    end
    check("fu_ready", bus_if.fu_ready, exp_r);
    if (use_lit) check("fu_ready_directed", bus_if.fu_ready, lit);
    if (!rn || mis) rr_m = 0;
    else if (order.size() > 0) rr_m = (order[order.size()-1] + 1) % F;
    if (order.size() > 0) begin
      r.valid = '0; r.prf = '0; r.rob = '0; r.val = '0; r.addr = '0; r.tkn = '0;
      for (int k = 0; k < order.size(); k++) begin
        r.valid[k] = 1'b1;
        r.prf[k]   = pprf[order[k]];
        r.rob[k]   = prob[order[k]];
        r.val[k]   = pval[order[k]];
        r.addr[k]  = paddr[order[k]];
        r.tkn[k]   = ptkn[order[k]];
        pv[order[k]] = 1'b0;
        n_in++;
      end
      exp_q.push_back(r);
    end
  endtask

  initial begin
    rec_t r;
    forever begin
      @(posedge clock);
      #1;
      if (mon_en && bus_if.cdb_valid != '0) begin
        for (int k = 0; k < N; k++) if (bus_if.cdb_valid[k]) n_out++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL cdb_unexpected: got valid %0h expected none", bus_if.cdb_valid);
        end else begin
          r = exp_q.pop_front();
          check("cdb_valid", bus_if.cdb_valid, r.valid);
          for (int k = 0; k < N; k++) begin
            if (r.valid[k]) begin
              check("cdb_dest_prf", bus_if.cdb_dest_prf[k*6 +: 6], r.prf[k]);
              check("cdb_rob_idx", bus_if.cdb_rob_idx[k*5 +: 5], r.rob[k]);
              check("cdb_value", bus_if.cdb_value[k*32 +: 32], r.val[k]);
              check("cdb_br_addr", bus_if.cdb_br_addr[k*32 +: 32], r.addr[k]);
              check("cdb_br_taken", bus_if.cdb_br_taken[k], r.tkn[k]);
            end
          end
        end
      end
    end
  end

  initial begin
    bus_if.branch_mispredict = 1'b0;
    bus_if.fu_valid = '0;
    bus_if.fu_dest_prf = '0;
    bus_if.fu_rob_idx = '0;
    bus_if.fu_value = '0;
    bus_if.fu_br_addr = '0;
    bus_if.fu_br_taken = '0;

    // Reset held with every requester valid.
    set_only(8'hFF);
    cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 1, 8'h00);
    @(posedge clock); #2;
    check("reset_cdb_valid", bus_if.cdb_valid, 4'b0000);
    check("reset_cdb_value", bus_if.cdb_value, '0);
    check("reset_cdb_dest_prf", bus_if.cdb_dest_prf, '0);
    mon_en = 1;
    cycle(1, 0, 1, 8'h0F);

    // Single requester FU5 with a known payload.
    set_only(8'h00);
    pv[5] = 1'b1; pprf[5] = 6'h02; prob[5] = 5'h02;
    pval[5] = 32'd69; paddr[5] = 32'd20; ptkn[5] = 1'b1;
    cycle(1, 0, 1, 8'h20);
    @(posedge clock); #2;
    check("t2_cdb_valid", bus_if.cdb_valid, 4'b0001);
    check("t2_prf", bus_if.cdb_dest_prf[5:0], 6'h02);
    check("t2_rob", bus_if.cdb_rob_idx[4:0], 5'h02);
    check("t2_value", bus_if.cdb_value[31:0], 32'd69);
    check("t2_br_addr", bus_if.cdb_br_addr[31:0], 32'd20);
    check("t2_taken", bus_if.cdb_br_taken[0], 1'b1);

    // Wrap from rr_ptr=6: FU7, FU1, FU2.
    set_only(8'h86);
    cycle(1, 0, 1, 8'h86);
    @(posedge clock); #2;
    check("t4_cdb_valid", bus_if.cdb_valid, 4'b0111);

    // Mispredict flushes the CDB and returns the pointer to 0.
    set_only(8'hFF);
    cycle(1, 0, 1, 8'h78);
    cycle(1, 1, 1, 8'h00);
    @(posedge clock); #2;
    check("t5_cdb_valid", bus_if.cdb_valid, 4'b0000);
    refill(); cycle(1, 0, 1, 8'h0F);
    refill(); cycle(1, 0, 1, 8'hF0);
    refill(); cycle(1, 0, 1, 8'h0F);

    // Six requesters: two wait one cycle with payload held.
    set_only(8'h3F);
    cycle(1, 0, 1, 8'h33);
    cycle(1, 0, 1, 8'h0C);
    cycle(1, 0, 1, 8'h00);

    // Randomized traffic with occasional mispredicts and resets.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < F; i++) if (!pv[i] && $urandom_range(1, 0) == 1) new_payload(i);
      cycle(($urandom_range(39, 0) != 0), ($urandom_range(19, 0) == 0), 0, 8'h00);
    end
    for (int t = 0; t < 5; t++) cycle(1, 0, 0, 8'h00);
    @(posedge clock); #2;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("in_out_count", 64'(n_out), 64'(n_in));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
